// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter among N_REQ byte requesters.
// Latency: req sampled at edge k -> gnt/Data_valid registered high for cycle k..k+1; done one cycle after busy falls.
// Backpressure: grants only in IDLE with busy=0; a frame owns the transmitter until done or err.
//
// Ports:
//   clk, rst (async, active-low)
//   req/req_data/req_par_en/req_par_type : per-requester byte and parity settings (byte i at [i*DATA_W +: DATA_W])
//   gnt/done/err                         : one-cycle event pulses (gnt/done one-hot per requester)
//   owner                                : index of the last granted requester
//   P_Data/Data_valid/Par_en/Par_type    : launch interface to UART_TX, busy is its frame-in-flight flag
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_W-1:0]     req_data,
  input  logic [N_REQ-1:0]            req_par_en,
  input  logic [N_REQ-1:0]            req_par_type,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            done,
  output logic                        err,
  output logic [$clog2(N_REQ)-1:0]    owner,
  output logic [DATA_W-1:0]           P_Data,
  output logic                        Data_valid,
  output logic                        Par_en,
  output logic                        Par_type,
  input  logic                        busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  // Scan start for the next arbitration; kept apart from owner so that
  // requester 0 has top priority out of reset while owner still reads 0.
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   p_data_q, p_data_d;
  logic                dv_q, dv_d;
  logic                par_en_q, par_en_d;
  logic                par_type_q, par_type_d;

  logic                found;
  logic [IW-1:0]       pick_idx;
  int                  scan_idx;

  // Round-robin pick: first set req scanning upward from ptr_q with wrap.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    scan_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req[scan_idx]) begin
        found    = 1'b1;
        pick_idx = IW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    gnt_d      = '0;
    done_d     = '0;
    err_d      = 1'b0;
    dv_d       = 1'b0;
    p_data_d   = p_data_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;

    case (state_q)
      IDLE: begin
        if (!busy && found) begin
          gnt_d[pick_idx] = 1'b1;
          dv_d            = 1'b1;
          p_data_d        = req_data[int'(pick_idx)*DATA_W +: DATA_W];
          par_en_d        = req_par_en[pick_idx];
          par_type_d      = req_par_type[pick_idx];
          owner_d         = pick_idx;
          // Advancing past the winner at grant time also covers the timeout path.
          ptr_d           = (pick_idx == IW'(N_REQ-1)) ? '0 : pick_idx + IW'(1);
          cnt_d           = '0;
          state_d         = WAIT_BUSY;
        end
      end

      WAIT_BUSY: begin
        if (busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT-1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      WAIT_DONE: begin
        // Frame length is bounded by the transmitter, so no timeout here.
        if (!busy) begin
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      owner_q    <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign owner      = owner_q;
  assign P_Data     = p_data_q;
  assign Data_valid = dv_q;
  assign Par_en     = par_en_q;
  assign Par_type   = par_type_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int FRAME_LEN = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_par_en = '0;
  logic [3:0]  req_par_type = '0;
  logic        busy = 1'b0;
  logic [3:0]  gnt, done;
  logic        err;
  logic [1:0]  owner;
  logic [7:0]  P_Data;
  logic        Data_valid, Par_en, Par_type;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .req_par_en(req_par_en), .req_par_type(req_par_type),
    .gnt(gnt), .done(done), .err(err), .owner(owner),
    .P_Data(P_Data), .Data_valid(Data_valid), .Par_en(Par_en), .Par_type(Par_type),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Transmitter model plus protocol monitor, evaluated on falling edges.
  bit         model_en = 1'b1;
  int         bcnt = 0;
  int         gnt_total = 0, done_total = 0, err_total = 0, viol = 0;
  logic [7:0] prev_pd = '0;
  logic       prev_pe = 1'b0, prev_pt = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if ($countones(gnt) > 1 || $countones(done) > 1) viol++;
        if (gnt != 0 && done != 0) viol++;
        if (err && done != 0) viol++;
        if (Data_valid && busy) viol++;
        if (Data_valid != (gnt != 0)) viol++;
        if (gnt == 0 && (P_Data !== prev_pd || Par_en !== prev_pe || Par_type !== prev_pt)) viol++;
        if (gnt != 0) gnt_total++;
        if (done != 0) done_total++;
        if (err) err_total++;
      end
      prev_pd = P_Data;
      prev_pe = Par_en;
      prev_pt = Par_type;
      if (model_en && Data_valid) begin
        busy = 1'b1;
        bcnt = FRAME_LEN;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) busy = 1'b0;
      end
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_gnt(input int maxc, output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    for (int c = 1; c <= maxc; c++) begin
      step();
      if (gnt != 0) begin
        idx = idx_of(gnt);
        cyc = c;
        return;
      end
    end
  endtask

  task automatic wait_done(input int maxc, output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    for (int c = 1; c <= maxc; c++) begin
      step();
      if (done != 0) begin
        idx = idx_of(done);
        cyc = c;
        return;
      end
    end
  endtask

  task automatic wait_err(input int maxc, output int cyc);
    cyc = 0;
    for (int c = 1; c <= maxc; c++) begin
      step();
      if (err) begin
        cyc = c;
        return;
      end
    end
  endtask

  task automatic test_reset;
    int idx, cyc;
    rst = 1'b0;
    req = 4'hF;
    repeat (3) step();
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %h expected 0", gnt); end
    checks++; if (Data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", Data_valid); end
    checks++; if (P_Data !== 8'h00) begin errors++; $display("FAIL reset_pdata: got %h expected 00", P_Data); end
    checks++; if (err !== 1'b0 || done !== 4'b0) begin errors++; $display("FAIL reset_err_done: got err=%b done=%h expected 0", err, done); end
    checks++; if (owner !== 2'd0 || Par_en !== 1'b0 || Par_type !== 1'b0) begin errors++; $display("FAIL reset_misc: got owner=%0d pe=%b pt=%b expected 0", owner, Par_en, Par_type); end
    rst = 1'b1;
    wait_gnt(5, idx, cyc);
    checks++; if (idx != 0 || cyc != 1) begin errors++; $display("FAIL reset_first_gnt: got idx=%0d cyc=%0d expected idx=0 cyc=1", idx, cyc); end
    req = 4'h0;
    wait_done(40, idx, cyc);
    checks++; if (idx != 0) begin errors++; $display("FAIL reset_first_done: got idx=%0d expected 0", idx); end
    step();
  endtask

  task automatic test_single_frame;
    int idx, cyc;
    req_data[23:16]  = 8'hA5;
    req_par_en[2]    = 1'b1;
    req_par_type[2]  = 1'b1;
    req = 4'b0100;
    wait_gnt(5, idx, cyc);
    checks++; if (gnt !== 4'b0100 || cyc != 1) begin errors++; $display("FAIL single_gnt: got gnt=%b cyc=%0d expected 0100 cyc=1", gnt, cyc); end
    checks++; if (Data_valid !== 1'b1 || P_Data !== 8'hA5) begin errors++; $display("FAIL single_launch: got dv=%b pdata=%h expected dv=1 pdata=a5", Data_valid, P_Data); end
    checks++; if (Par_en !== 1'b1 || Par_type !== 1'b1) begin errors++; $display("FAIL single_parity: got pe=%b pt=%b expected 1 1", Par_en, Par_type); end
    req = 4'b0000;
    req_data[23:16] = 8'h00;
    step();
    checks++; if (Data_valid !== 1'b0 || gnt !== 4'b0) begin errors++; $display("FAIL single_pulse: got dv=%b gnt=%b expected 0", Data_valid, gnt); end
    wait_done(40, idx, cyc);
    checks++; if (done !== 4'b0100 || cyc != FRAME_LEN) begin errors++; $display("FAIL single_done: got done=%b cyc=%0d expected 0100 cyc=%0d", done, cyc, FRAME_LEN); end
    checks++; if (P_Data !== 8'hA5 || Par_en !== 1'b1 || Par_type !== 1'b1) begin errors++; $display("FAIL single_hold: got pdata=%h pe=%b pt=%b expected a5 1 1", P_Data, Par_en, Par_type); end
    step();
  endtask

  task automatic test_all_four;
    int idx, cyc, exp;
    req_data     = 32'h13121110;
    req_par_en   = 4'b0000;
    req_par_type = 4'b0000;
    req = 4'hF;
    for (int g = 0; g < 8; g++) begin
      exp = (3 + g) % 4;  // last owner was requester 2
      wait_gnt(40, idx, cyc);
      checks++; if (idx != exp || P_Data !== 8'h10 + 8'(exp)) begin errors++; $display("FAIL rr_order[%0d]: got idx=%0d pdata=%h expected idx=%0d pdata=%h", g, idx, P_Data, exp, 8'h10 + 8'(exp)); end
    end
    req = 4'h0;
    wait_done(40, idx, cyc);
    checks++; if (idx != 2) begin errors++; $display("FAIL rr_last_done: got %0d expected 2", idx); end
    checks++; if (gnt_total != done_total || viol != 0) begin errors++; $display("FAIL rr_balance: got gnts=%0d dones=%0d viol=%0d expected equal and 0", gnt_total, done_total, viol); end
    step();
  endtask

  task automatic test_mixed_parity;
    int idx, cyc, exp;
    req_par_en   = 4'b0010;
    req_par_type = 4'b0001;
    req = 4'b0011;
    for (int g = 0; g < 4; g++) begin
      exp = g % 2;
      wait_gnt(40, idx, cyc);
      checks++; if (idx != exp || Par_en !== (exp == 1) || Par_type !== (exp == 0)) begin errors++; $display("FAIL mixed_par[%0d]: got idx=%0d pe=%b pt=%b expected idx=%0d pe=%b pt=%b", g, idx, Par_en, Par_type, exp, exp == 1, exp == 0); end
    end
    req = 4'h0;
    wait_done(40, idx, cyc);
    checks++; if (viol != 0) begin errors++; $display("FAIL mixed_stable: got viol=%0d expected 0", viol); end
    step();
  endtask

  task automatic test_timeout;
    int idx, cyc, d0;
    d0 = done_total;
    model_en = 1'b0;
    req = 4'b1100;
    wait_gnt(5, idx, cyc);
    checks++; if (idx != 2) begin errors++; $display("FAIL timeout_gnt1: got %0d expected 2", idx); end
    wait_err(40, cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL timeout_err1: got cyc=%0d expected 16", cyc); end
    wait_gnt(3, idx, cyc);
    checks++; if (idx != 3 || cyc != 1) begin errors++; $display("FAIL timeout_next: got idx=%0d cyc=%0d expected 3 1", idx, cyc); end
    req = 4'h0;
    wait_err(40, cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL timeout_err2: got cyc=%0d expected 16", cyc); end
    model_en = 1'b1;
    checks++; if (done_total != d0 || err_total != 2) begin errors++; $display("FAIL timeout_counts: got dones=%0d errs=%0d expected %0d 2", done_total, err_total, d0); end
    step();
  endtask

  task automatic test_reset_mid_frame;
    int idx, cyc, d0, e0;
    req = 4'b0001;
    wait_gnt(5, idx, cyc);
    checks++; if (idx != 0) begin errors++; $display("FAIL midrst_gnt: got %0d expected 0", idx); end
    req = 4'h0;
    repeat (4) step();
    d0 = done_total;
    e0 = err_total;
    rst = 1'b0;
    #1;
    checks++; if (P_Data !== 8'h00 || Par_en !== 1'b0 || owner !== 2'd0 || done !== 4'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst_clear: got pdata=%h pe=%b owner=%0d done=%b err=%b expected 0", P_Data, Par_en, owner, done, err); end
    repeat (15) step();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (done_total != d0 || err_total != e0) begin errors++; $display("FAIL midrst_silent: got dones=%0d errs=%0d expected %0d %0d", done_total, err_total, d0, e0); end
    req = 4'b1000;
    wait_gnt(5, idx, cyc);
    checks++; if (gnt !== 4'b1000 || cyc != 1) begin errors++; $display("FAIL midrst_regnt: got gnt=%b cyc=%0d expected 1000 1", gnt, cyc); end
    wait_done(40, idx, cyc);
    checks++; if (done !== 4'b1000) begin errors++; $display("FAIL b2b_done: got %b expected 1000", done); end
    wait_gnt(5, idx, cyc);
    checks++; if (idx != 3 || cyc != 1) begin errors++; $display("FAIL b2b_gnt: got idx=%0d cyc=%0d expected 3 1", idx, cyc); end
    req = 4'h0;
    wait_done(40, idx, cyc);
    checks++; if (viol != 0 || idx != 3) begin errors++; $display("FAIL final_protocol: got viol=%0d done_idx=%0d expected 0 3", viol, idx); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_all_four();
    test_mixed_parity();
    test_timeout();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule
